// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: control word, multiplier operand selects
// and the result-width helper.
package alu_pkg;

   typedef struct packed {
      logic       pre_x_en;
      logic       pre_x_sub;
      logic       mul_x_en;
      logic [2:0] mul_x_sel;
      logic       pre_y_en;
      logic       pre_y_sub;
      logic       mul_y_en;
      logic [2:0] mul_y_sel;
      logic       post_en;
      logic       post_sub;
      logic       post_sel;
   } alu_ctrl_t;

   localparam logic [2:0] MUL_SEL_X0    = 3'd0;
   localparam logic [2:0] MUL_SEL_X1    = 3'd1;
   localparam logic [2:0] MUL_SEL_Y0    = 3'd2;
   localparam logic [2:0] MUL_SEL_Y1    = 3'd3;
   localparam logic [2:0] MUL_SEL_OTHER = 3'd4;
   localparam logic [2:0] MUL_SEL_ONE   = 3'd5;
   localparam logic [2:0] MUL_SEL_TWO   = 3'd6;
   localparam logic [2:0] MUL_SEL_SQ    = 3'd7;

   function automatic int alu_rw(input int w);
      return 2 * w + 2;
   endfunction

endpackage

// File: rtl/alu_pipe_nb_if.sv
// Command/result bundle of alu_pipe_nb. acc_en/acc_clr exist only when
// ALU_PIPE_ACC_EN is defined.
interface alu_pipe_nb_if import alu_pkg::*; #(parameter int W = 4);

   localparam int RW = alu_rw(W);

   logic [W-1:0]  x0;
   logic [W-1:0]  x1;
   logic [W-1:0]  y0;
   logic [W-1:0]  y1;
   alu_ctrl_t     ctrl;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_q;
   logic          carry_q;
   logic          busy;
`ifdef ALU_PIPE_ACC_EN
   logic          acc_en;
   logic          acc_clr;

   modport master (
      output x0, x1, y0, y1, ctrl, cmd_valid, res_ready, acc_en, acc_clr,
      input  cmd_ready, res_valid, res_q, carry_q, busy
   );

   modport slave (
      input  x0, x1, y0, y1, ctrl, cmd_valid, res_ready, acc_en, acc_clr,
      output cmd_ready, res_valid, res_q, carry_q, busy
   );
`else
   modport master (
      output x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
      input  cmd_ready, res_valid, res_q, carry_q, busy
   );

   modport slave (
      input  x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
      output cmd_ready, res_valid, res_q, carry_q, busy
   );
`endif

endinterface

// File: rtl/alu_lane_nb.sv
// One ALU lane: combinational pre add/sub (S1) and multiply/select (S2).
// The pipeline registers between the two halves live in the top.
module alu_lane_nb import alu_pkg::*; #(
   parameter int W  = 4,
   parameter int RW = alu_rw(W)
) (
   input  logic [W-1:0]          a0,
   input  logic [W-1:0]          a1,
   input  logic                  pre_en,
   input  logic                  pre_sub,
   output logic signed [W+1:0]   p,
   input  logic signed [W+1:0]   p_q,
   input  logic signed [W+1:0]   p_other,
   input  logic [W-1:0]          op_x0,
   input  logic [W-1:0]          op_x1,
   input  logic [W-1:0]          op_y0,
   input  logic [W-1:0]          op_y1,
   input  logic                  mul_en,
   input  logic [2:0]            mul_sel,
   output logic [RW-1:0]         m
);

   // Two extra bits: a full-scale sum stays positive and a difference keeps its sign.
   logic [W+1:0]         a0_ext;
   logic [W+1:0]         a1_ext;
   logic signed [W+1:0]  op;
   logic signed [RW-1:0] p_wide;
   logic signed [RW-1:0] op_wide;

   always_comb begin
      a0_ext = {2'b00, a0};
      a1_ext = {2'b00, a1};
      p      = a0_ext;
      if (pre_en) begin
         if (pre_sub) p = a0_ext - a1_ext;
         else         p = a0_ext + a1_ext;
      end
   end

   always_comb begin
      op = p_q;
      case (mul_sel)
         MUL_SEL_X0:    op = {2'b00, op_x0};
         MUL_SEL_X1:    op = {2'b00, op_x1};
         MUL_SEL_Y0:    op = {2'b00, op_y0};
         MUL_SEL_Y1:    op = {2'b00, op_y1};
         MUL_SEL_OTHER: op = p_other;
         MUL_SEL_ONE:   op = {{W{1'b0}}, 2'b01};
         MUL_SEL_TWO:   op = {{W{1'b0}}, 2'b10};
         MUL_SEL_SQ:    op = p_q;
         default:       op = p_q;
      endcase
   end

   always_comb begin
      p_wide  = {{(RW-W-2){p_q[W+1]}}, p_q};
      op_wide = {{(RW-W-2){op[W+1]}}, op};
      m       = mul_en ? p_wide * op_wide : p_wide;
   end

endmodule

// File: rtl/alu_pipe_nb.sv
// Three-stage valid/ready ALU pipeline (pre -> mul -> post) on W-bit operands.
// Optional result accumulator is compiled in with ALU_PIPE_ACC_EN.
module alu_pipe_nb import alu_pkg::*; #(
   parameter int W = 4
) (
   input logic            clk,
   input logic            rst_n,
   alu_pipe_nb_if.slave   bus
);

   localparam int RW = alu_rw(W);
   localparam int PW = W + 2;

   alu_ctrl_t ctrl;
   logic      v1, v2, v3;
   logic      adv1, adv2;
   logic      cmd_ready;
   logic      accept;

   logic signed [PW-1:0] p_x, p_y;
   logic [RW-1:0]        m_x, m_y;

   logic signed [PW-1:0] s1_px, s1_py;
   logic [W-1:0]         s1_x0, s1_x1, s1_y0, s1_y1;
   logic                 s1_mul_x_en, s1_mul_y_en;
   logic [2:0]           s1_mul_x_sel, s1_mul_y_sel;
   logic                 s1_post_en, s1_post_sub, s1_post_sel;

   logic [RW-1:0]        s2_mx, s2_my;
   logic                 s2_post_en, s2_post_sub, s2_post_sel;

   logic [RW:0]          sum_ext;
   logic [RW-1:0]        diff;
   logic [RW-1:0]        post_r;
   logic                 post_c;
   logic [RW-1:0]        out_r;
   logic                 out_c;
   logic [RW-1:0]        res_q;
   logic                 carry_q;

   assign ctrl = bus.ctrl;

   // Backpressure ripples combinationally from res_ready to cmd_ready.
   assign adv2      = v2 && (!v3 || bus.res_ready);
   assign adv1      = v1 && (!v2 || adv2);
   assign cmd_ready = !v1 || adv1;
   assign accept    = bus.cmd_valid && cmd_ready;

   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = v3;
   assign bus.busy      = v1 || v2 || v3;
   assign bus.res_q     = res_q;
   assign bus.carry_q   = carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v1 <= accept || (v1 && !adv1);
         v2 <= adv1 || (v2 && !adv2);
         v3 <= adv2 || (v3 && !bus.res_ready);
      end
   end

   alu_lane_nb #(.W(W), .RW(RW)) u_lane_x (
      .a0      (bus.x0),
      .a1      (bus.x1),
      .pre_en  (ctrl.pre_x_en),
      .pre_sub (ctrl.pre_x_sub),
      .p       (p_x),
      .p_q     (s1_px),
      .p_other (s1_py),
      .op_x0   (s1_x0),
      .op_x1   (s1_x1),
      .op_y0   (s1_y0),
      .op_y1   (s1_y1),
      .mul_en  (s1_mul_x_en),
      .mul_sel (s1_mul_x_sel),
      .m       (m_x)
   );

   alu_lane_nb #(.W(W), .RW(RW)) u_lane_y (
      .a0      (bus.y0),
      .a1      (bus.y1),
      .pre_en  (ctrl.pre_y_en),
      .pre_sub (ctrl.pre_y_sub),
      .p       (p_y),
      .p_q     (s1_py),
      .p_other (s1_px),
      .op_x0   (s1_x0),
      .op_x1   (s1_x1),
      .op_y0   (s1_y0),
      .op_y1   (s1_y1),
      .mul_en  (s1_mul_y_en),
      .mul_sel (s1_mul_y_sel),
      .m       (m_y)
   );

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_px        <= p_x;
         s1_py        <= p_y;
         s1_x0        <= bus.x0;
         s1_x1        <= bus.x1;
         s1_y0        <= bus.y0;
         s1_y1        <= bus.y1;
         s1_mul_x_en  <= ctrl.mul_x_en;
         s1_mul_x_sel <= ctrl.mul_x_sel;
         s1_mul_y_en  <= ctrl.mul_y_en;
         s1_mul_y_sel <= ctrl.mul_y_sel;
         s1_post_en   <= ctrl.post_en;
         s1_post_sub  <= ctrl.post_sub;
         s1_post_sel  <= ctrl.post_sel;
      end
      if (adv1) begin
         s2_mx       <= m_x;
         s2_my       <= m_y;
         s2_post_en  <= s1_post_en;
         s2_post_sub <= s1_post_sub;
         s2_post_sel <= s1_post_sel;
      end
   end

   always_comb begin
      sum_ext = {1'b0, s2_mx} + {1'b0, s2_my};
      diff    = s2_mx - s2_my;
      post_r  = s2_post_sel ? s2_my : s2_mx;
      post_c  = 1'b0;
      if (s2_post_en) begin
         if (s2_post_sub) begin
            post_r = diff;
            post_c = s2_mx < s2_my;
         end else begin
            post_r = sum_ext[RW-1:0];
            post_c = sum_ext[RW];
         end
      end
   end

`ifdef ALU_PIPE_ACC_EN
   logic          s1_acc_en, s1_acc_clr;
   logic          s2_acc_en, s2_acc_clr;
   logic [RW-1:0] acc;
   logic [RW-1:0] acc_base;
   logic [RW:0]   acc_sum;

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_acc_en  <= bus.acc_en;
         s1_acc_clr <= bus.acc_clr;
      end
      if (adv1) begin
         s2_acc_en  <= s1_acc_en;
         s2_acc_clr <= s1_acc_clr;
      end
   end

   always_comb begin
      acc_base = s2_acc_clr ? '0 : acc;
      acc_sum  = {1'b0, acc_base} + {1'b0, post_r};
      out_r    = s2_acc_en ? acc_sum[RW-1:0] : post_r;
      out_c    = s2_acc_en ? acc_sum[RW]     : post_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (adv2 && (s2_acc_en || s2_acc_clr)) begin
         acc <= out_r;
      end
   end
`else
   always_comb begin
      out_r = post_r;
      out_c = post_c;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
      end else if (adv2) begin
         res_q   <= out_r;
         carry_q <= out_c;
      end
   end

endmodule

// File: tb/tb_alu_pipe_nb.sv
// Bench for alu_pipe_nb: directed vectors, fill/drain, async reset, wide
// operands, randomized traffic against an arithmetic model (+ accumulator).
module tb_alu_pipe_nb;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   alu_pipe_nb_if #(.W(4)) bus ();
   alu_pipe_nb_if #(.W(8)) bus8 ();

   alu_pipe_nb #(.W(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_pipe_nb #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] x0, x1, y0, y1;
      alu_ctrl_t  c;
      logic [9:0] r;
      logic       cy;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic alu_ctrl_t ctl(input logic pxe, pxs, mxe, input logic [2:0] mxs,
                                     input logic pye, pys, mye, input logic [2:0] mys,
                                     input logic pe, ps, psel);
      alu_ctrl_t c;
      c.pre_x_en = pxe; c.pre_x_sub = pxs; c.mul_x_en = mxe; c.mul_x_sel = mxs;
      c.pre_y_en = pye; c.pre_y_sub = pys; c.mul_y_en = mye; c.mul_y_sel = mys;
      c.post_en = pe; c.post_sub = ps; c.post_sel = psel;
      return c;
   endfunction

   function automatic longint pick(input logic [2:0] sel, input longint own, other,
                                   input longint a, b, c, d);
      case (sel)
         3'd0: return a;
         3'd1: return b;
         3'd2: return c;
         3'd3: return d;
         3'd4: return other;
         3'd5: return 1;
         3'd6: return 2;
         default: return own;
      endcase
   endfunction

   // Arithmetic reference for W=4 (RW=10): returns {carry, result}.
   function automatic logic [10:0] model(input logic [3:0] x0, x1, y0, y1, input alu_ctrl_t c);
      longint a, b, d, e, px, py, mx, my, mxu, myu, r, cy;
      longint mask;
      mask = 1023;
      a = longint'(x0); b = longint'(x1); d = longint'(y0); e = longint'(y1);
      px = c.pre_x_en ? (c.pre_x_sub ? a - b : a + b) : a;
      py = c.pre_y_en ? (c.pre_y_sub ? d - e : d + e) : d;
      mx = c.mul_x_en ? px * pick(c.mul_x_sel, px, py, a, b, d, e) : px;
      my = c.mul_y_en ? py * pick(c.mul_y_sel, py, px, a, b, d, e) : py;
      mxu = mx & mask;
      myu = my & mask;
      cy = 0;
      if (!c.post_en) r = c.post_sel ? myu : mxu;
      else if (c.post_sub) begin
         r = (mxu - myu) & mask;
         cy = (mxu < myu) ? 1 : 0;
      end else begin
         r = (mxu + myu) & mask;
         cy = (mxu + myu) >> 10;
      end
      return {cy[0], r[9:0]};
   endfunction

   // Issue one command with res_ready=1; lat counts edges from accept to res_valid.
   task automatic do_op(input logic [3:0] x0, x1, y0, y1, input alu_ctrl_t c,
                        input logic ae, input logic ac,
                        output logic [9:0] r, output logic cy, output int lat);
      bit acc_ok;
      acc_ok = 0;
      lat = -1;
      r = 'x;
      cy = 1'bx;
      bus.x0 = x0; bus.x1 = x1; bus.y0 = y0; bus.y1 = y1; bus.ctrl = c;
`ifdef ALU_PIPE_ACC_EN
      bus.acc_en = ae; bus.acc_clr = ac;
`else
      if (ae || ac) $display("note: accumulator controls ignored in this build");
`endif
      bus.cmd_valid = 1'b1;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin acc_ok = 1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
`ifdef ALU_PIPE_ACC_EN
      bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
`endif
      if (acc_ok) begin
         for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
               lat = i; r = bus.res_q; cy = bus.carry_q;
               break;
            end
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [9:0]  r;
      logic        cy;
      int          lat;
      int          sent, got, first_cyc, last_cyc, cnt;
      logic [9:0]  seen[$];
      logic [10:0] exp_q[$];
      logic [10:0] held;
      logic [10:0] expv;
      bit          stalled, new_op;
      logic [14:0] rc;

      bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0; bus.ctrl = '0;
      bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
      bus8.x0 = '0; bus8.x1 = '0; bus8.y0 = '0; bus8.y1 = '0; bus8.ctrl = '0;
      bus8.cmd_valid = 1'b0; bus8.res_ready = 1'b1;
`ifdef ALU_PIPE_ACC_EN
      bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
      bus8.acc_en = 1'b0; bus8.acc_clr = 1'b0;
`endif

      vt[0] = '{4'd5, 4'd3, 4'd2, 4'd1, ctl(1,0,1,3'd2, 1,1,0,3'd0, 1,0,0), 10'd17,  1'b0};
      vt[1] = '{4'd0, 4'd0, 4'd1, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,1,0), 10'h3FF, 1'b1};
      vt[2] = '{4'd4, 4'd0, 4'd9, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 0,0,1), 10'd9,   1'b0};
      vt[3] = '{4'd12,4'd0, 4'd9, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 0,0,0), 10'd12,  1'b0};
      vt[4] = '{4'd2, 4'd7, 4'd0, 4'd0, ctl(1,1,1,3'd7, 0,0,0,3'd0, 1,0,0), 10'd25,  1'b0};
      vt[5] = '{4'd3, 4'd0, 4'd4, 4'd4, ctl(0,0,1,3'd4, 1,0,1,3'd5, 1,1,0), 10'd16,  1'b0};
      vt[6] = '{4'd15,4'd15,4'd15,4'd15,ctl(1,0,1,3'd7, 1,0,1,3'd7, 1,0,0), 10'd776, 1'b1};
      vt[7] = '{4'd0, 4'd15,4'd0, 4'd0, ctl(1,1,1,3'd6, 0,0,0,3'd0, 1,0,0), 10'd994, 1'b0};
      vt[8] = '{4'd1, 4'd15,4'd3, 4'd15,ctl(1,1,1,3'd3, 0,0,1,3'd0, 1,1,0), 10'd811, 1'b0};

      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_res_q", bus.res_q, 0);
      chk("rst_carry_q", bus.carry_q, 0);

      foreach (vt[i]) begin
         do_op(vt[i].x0, vt[i].x1, vt[i].y0, vt[i].y1, vt[i].c, 1'b0, 1'b0, r, cy, lat);
         chk($sformatf("vec%0d_lat", i), lat, 3);
         chk($sformatf("vec%0d_res", i), r, vt[i].r);
         chk($sformatf("vec%0d_carry", i), cy, vt[i].cy);
      end

      // Fill with res_ready low, then drain.
      bus.res_ready = 1'b0;
      bus.ctrl = '0; bus.y0 = '0; bus.x0 = 4'd1;
      bus.cmd_valid = 1'b1;
      sent = 0;
      for (int cyc = 0; cyc < 12 && sent < 3; cyc++) begin
         @(negedge clk);
         if (bus.cmd_valid && bus.cmd_ready) sent++;
         @(posedge clk); #1;
         bus.x0 = 4'(sent + 1);
      end
      @(negedge clk);
      chk("cap_sent", sent, 3);
      chk("cap_cmd_ready_full", bus.cmd_ready, 0);
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (bus.cmd_valid && bus.cmd_ready) sent++;
         if (bus.res_valid) begin
            seen.push_back(bus.res_q);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         @(posedge clk); #1;
         if (sent == 4) bus.cmd_valid = 1'b0;
      end
      chk("cap_count", seen.size(), 4);
      chk("cap_back_to_back", last_cyc - first_cyc, 3);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         chk($sformatf("cap_order%0d", i), seen[i], i + 1);

      // Randomized traffic with random backpressure.
      sent = 0; got = 0; stalled = 0; held = '0; new_op = 1;
      for (int cyc = 0; cyc < 4000 && got < 200; cyc++) begin
         if (new_op) begin
            bus.x0 = 4'($urandom); bus.x1 = 4'($urandom);
            bus.y0 = 4'($urandom); bus.y1 = 4'($urandom);
            rc = 15'($urandom);
            bus.ctrl = alu_ctrl_t'(rc);
            new_op = 0;
         end
         bus.cmd_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
         bus.res_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (stalled) begin
            chk("rnd_hold_valid", bus.res_valid, 1);
            chk("rnd_hold_data", {bus.carry_q, bus.res_q}, held);
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            exp_q.push_back(model(bus.x0, bus.x1, bus.y0, bus.y1, bus.ctrl));
            sent++;
            new_op = 1;
         end
         if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL rnd_extra: got %0h, expected no result", bus.res_q);
            end else begin
               expv = exp_q.pop_front();
               chk("rnd_res", {bus.carry_q, bus.res_q}, expv);
            end
            got++;
         end
         stalled = bus.res_valid && !bus.res_ready;
         held = {bus.carry_q, bus.res_q};
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      chk("rnd_count", got, 200);
      chk("rnd_queue_empty", exp_q.size(), 0);

      // Async reset with two ops in flight.
      bus.res_ready = 1'b0;
      bus.ctrl = '0; bus.x0 = 4'd7; bus.cmd_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.x0 = 4'd8;
      @(negedge clk);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy_before", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_res_valid", bus.res_valid, 0);
      chk("rst_mid_busy", bus.busy, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      bus.res_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.res_valid) cnt++;
         @(posedge clk); #1;
      end
      chk("rst_no_stale", cnt, 0);
      do_op(4'd6, 4'd2, 4'd1, 4'd0, ctl(1,1,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b0, 1'b0, r, cy, lat);
      chk("rst_fresh_res", r, 5);

      // Wide operands: (255+255)^2.
      bus8.x0 = 8'd255; bus8.x1 = 8'd255;
      bus8.ctrl = ctl(1,0,1,3'd7, 0,0,0,3'd0, 1,0,0);
      bus8.cmd_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus8.cmd_ready) begin cnt = 1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus8.cmd_valid = 1'b0;
      lat = -1;
      for (int i = 1; i < 20 && cnt == 1; i++) begin
         @(negedge clk);
         if (bus8.res_valid) begin
            lat = i;
            chk("w8_res", bus8.res_q, 260100);
            chk("w8_carry", bus8.carry_q, 0);
            break;
         end
         @(posedge clk); #1;
      end
      chk("w8_lat", lat, 3);
      @(posedge clk); #1;

`ifdef ALU_PIPE_ACC_EN
      do_op(4'd5, 4'd0, 4'd0, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b1, 1'b1, r, cy, lat);
      chk("acc_first", r, 5);
      do_op(4'd5, 4'd0, 4'd0, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b1, 1'b0, r, cy, lat);
      chk("acc_second", r, 10);
      do_op(4'd5, 4'd0, 4'd0, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b1, 1'b0, r, cy, lat);
      chk("acc_third", r, 15);
      chk("acc_carry", cy, 0);
      do_op(4'd5, 4'd0, 4'd0, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b0, 1'b0, r, cy, lat);
      chk("acc_bypass", r, 5);
      do_op(4'd5, 4'd0, 4'd0, 4'd0, ctl(0,0,0,3'd0, 0,0,0,3'd0, 1,0,0), 1'b1, 1'b0, r, cy, lat);
      chk("acc_held", r, 20);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
